// File: rtl/mem_arbiter.sv
// Unified RAM port arbiter between instruction fetch and load/store requesters.
// Optional I-side anti-starvation counter enabled by defining MEM_ARB_STARVE_EN.
module mem_arbiter #(
    parameter int WORD_W = 32
`ifdef MEM_ARB_STARVE_EN
    , parameter int STARVE_MAX = 4
`endif
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              ihit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dhit,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DGRANT = 2'd1;
    localparam logic [1:0] IGRANT = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       d_req;
    logic       ram_done;
    logic       starve_grant;

    assign d_req    = dREN | dWEN;
    assign ram_done = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);

`ifdef MEM_ARB_STARVE_EN
    logic [2:0] starve_cnt;

    assign starve_grant = iREN && (starve_cnt == STARVE_MAX[2:0]);

    // Counts D grants taken while the I-side was waiting in IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= 3'd0;
        end else if (state == IDLE) begin
            if (!iREN || next_state == IGRANT)
                starve_cnt <= 3'd0;
            else if (next_state == DGRANT)
                starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign starve_grant = 1'b0;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no
    // path through the case can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_req && !starve_grant)
                    next_state = DGRANT;
                else if (iREN)
                    next_state = IGRANT;
            end
            DGRANT: begin
                if (!d_req || ram_done)
                    next_state = IDLE;
            end
            IGRANT: begin
                if (!iREN || ram_done)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state is sequential, so it uses non-blocking assignment and the
    // asynchronous active-low reset forces IDLE without waiting for a clock.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Outputs are purely combinational so a dropped request releases the RAM
    // in the same cycle and reset clears the enables immediately.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        iload    = '0;
        dload    = '0;
        case (state)
            DGRANT: begin
                if (d_req) begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (ramstate == RAM_ACCESS) begin
                        dhit  = 1'b1;
                        dload = ramload;
                    end
                end
            end
            IGRANT: begin
                if (iREN) begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (ramstate == RAM_ACCESS) begin
                        ihit  = 1'b1;
                        iload = ramload;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int W = 32;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          iREN = 1'b0;
    logic [W-1:0]  iaddr = '0;
    logic [W-1:0]  iload;
    logic          ihit;
    logic          dREN = 1'b0;
    logic          dWEN = 1'b0;
    logic [W-1:0]  daddr = '0;
    logic [W-1:0]  dstore = '0;
    logic [W-1:0]  dload;
    logic          dhit;
    logic          ramREN;
    logic          ramWEN;
    logic [W-1:0]  ramaddr;
    logic [W-1:0]  ramstore;
    logic [W-1:0]  ramload = '0;
    logic [1:0]    ramstate = FREE;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.WORD_W(W)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        ramstate = ACCESS;
        ramload = 32'hFFFF_FFFF;
        iREN = 1'b1; dREN = 1'b1;
        tick();
        checks++;
        if ({ramREN, ramWEN, ihit, dhit} !== 4'b0000 || ramaddr !== '0 || ramstore !== '0
            || iload !== '0 || dload !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ren/wen/ihit/dhit=%b addr=%h store=%h iload=%h dload=%h, required all 0",
                     {ramREN, ramWEN, ihit, dhit}, ramaddr, ramstore, iload, dload);
        end
        idle_inputs();
        nRST = 1'b1;
        tick();
        checks++;
        if ({ramREN, ramWEN, ihit, dhit} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release_idle: ren/wen/ihit/dhit=%b required 0000", {ramREN, ramWEN, ihit, dhit});
        end
    endtask

    task automatic test_ifetch();
        iREN = 1'b1; iaddr = 32'h40;
        tick();
        ramstate = BUSY;
        #1;
        checks++;
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || ihit !== 1'b0 || dhit !== 1'b0) begin
            failures++;
            $display("FAIL ifetch_grant: ren=%b wen=%b addr=%h ihit=%b dhit=%b, required 1 0 00000040 0 0",
                     ramREN, ramWEN, ramaddr, ihit, dhit);
        end
        tick();
        ramstate = ACCESS; ramload = 32'h2000_0001;
        #1;
        checks++;
        if (ihit !== 1'b1 || iload !== 32'h2000_0001 || dhit !== 1'b0 || dload !== '0) begin
            failures++;
            $display("FAIL ifetch_hit: ihit=%b iload=%h dhit=%b, required 1 20000001 0", ihit, iload, dhit);
        end
        tick();
        iREN = 1'b0; ramstate = FREE;
        #1;
        checks++;
        if (ihit !== 1'b0 || iload !== '0 || ramREN !== 1'b0 || dhit !== 1'b0) begin
            failures++;
            $display("FAIL ifetch_single_strobe: ihit=%b iload=%h ren=%b, required 0 0 0", ihit, iload, ramREN);
        end
        tick();
    endtask

    task automatic test_priority();
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
        tick();
        ramstate = ACCESS; ramload = 32'h1234_5678;
        #1;
        checks++;
        if (ramaddr !== 32'h100 || ramREN !== 1'b1 || dhit !== 1'b1 || dload !== 32'h1234_5678 || ihit !== 1'b0) begin
            failures++;
            $display("FAIL priority_dgrant: addr=%h ren=%b dhit=%b dload=%h ihit=%b, required 00000100 1 1 12345678 0",
                     ramaddr, ramREN, dhit, dload, ihit);
        end
        tick();
        dREN = 1'b0;
        #1;
        checks++;
        if (ramREN !== 1'b0 || ihit !== 1'b0 || dhit !== 1'b0) begin
            failures++;
            $display("FAIL priority_idle_gap: ren=%b ihit=%b dhit=%b, required 0 0 0", ramREN, ihit, dhit);
        end
        tick();
        ramload = 32'hCAFE_0044;
        #1;
        checks++;
        if (ramaddr !== 32'h44 || ramREN !== 1'b1 || ihit !== 1'b1 || iload !== 32'hCAFE_0044) begin
            failures++;
            $display("FAIL priority_igrant: addr=%h ren=%b ihit=%b iload=%h, required 00000044 1 1 cafe0044",
                     ramaddr, ramREN, ihit, iload);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_write_busy();
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
        tick();
        for (int c = 1; c <= 4; c++) begin
            ramstate = (c == 4) ? ACCESS : BUSY;
            #1;
            checks++;
            if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'hDEAD_BEEF
                || dhit !== (c == 4) || ihit !== 1'b0) begin
                failures++;
                $display("FAIL write_cycle%0d: wen=%b ren=%b addr=%h store=%h dhit=%b, required 1 0 00000080 deadbeef %b",
                         c, ramWEN, ramREN, ramaddr, ramstore, dhit, (c == 4));
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (ramWEN !== 1'b0 || dhit !== 1'b0) begin
            failures++;
            $display("FAIL write_release: wen=%b dhit=%b, required 0 0", ramWEN, dhit);
        end
        tick();
    endtask

    task automatic test_error();
        dREN = 1'b1; daddr = 32'h200;
        tick();
        ramstate = ERROR;
        #1;
        checks++;
        if (ramREN !== 1'b1 || dhit !== 1'b0 || dload !== '0) begin
            failures++;
            $display("FAIL error_no_hit: ren=%b dhit=%b dload=%h, required 1 0 0", ramREN, dhit, dload);
        end
        tick();
        ramstate = FREE;
        #1;
        checks++;
        if (ramREN !== 1'b0 || dhit !== 1'b0) begin
            failures++;
            $display("FAIL error_to_idle: ren=%b dhit=%b, required 0 0", ramREN, dhit);
        end
        tick();
        ramstate = ACCESS; ramload = 32'h0BAD_F00D;
        #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h200 || dhit !== 1'b1 || dload !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL error_regrant: ren=%b addr=%h dhit=%b dload=%h, required 1 00000200 1 0badf00d",
                     ramREN, ramaddr, dhit, dload);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        iREN = 1'b1; iaddr = 32'h300;
        tick();
        ramstate = BUSY;
        #1;
        checks++;
        if (ramREN !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_granted: ren=%b required 1", ramREN);
        end
        #1 nRST = 1'b0;
        #1;
        checks++;
        if (ramREN !== 1'b0 || ramaddr !== '0 || ihit !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_drop: ren=%b addr=%h ihit=%b, required 0 0 0", ramREN, ramaddr, ihit);
        end
        ramstate = ACCESS; ramload = 32'h5555_AAAA;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (ihit) pulses++;
        end
        iREN = 1'b0;
        nRST = 1'b1;
        tick();
        if (ihit) pulses++;
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL rstmid_no_ihit: ihit pulses=%0d required 0", pulses);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_starve();
        int d_hits, i_hits, d_before_i;
        d_hits = 0; i_hits = 0; d_before_i = -1;
        iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; daddr = 32'h600;
        ramstate = ACCESS;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (dhit && ihit) begin
                checks++;
                failures++;
                $display("FAIL starve_both_hits: cycle %0d ihit and dhit both 1", c);
            end
            if (dhit) d_hits++;
            if (ihit) begin
                if (i_hits == 0) d_before_i = d_hits;
                i_hits++;
            end
        end
`ifdef MEM_ARB_STARVE_EN
        checks++;
        if (d_before_i !== 4) begin
            failures++;
            $display("FAIL starve_limit: D grants before first I grant=%0d required 4", d_before_i);
        end
`else
        checks++;
        if (i_hits !== 0 || d_hits !== 10) begin
            failures++;
            $display("FAIL strict_priority: ihits=%0d dhits=%0d required 0 10", i_hits, d_hits);
        end
`endif
        idle_inputs();
        tick();
        tick();
    endtask

    // Reference model: who currently owns the RAM port (0 none, 1 data, 2 instr)
    // and how many D grants the waiting I-side has conceded.
    task automatic test_random();
        int owner, conceded, nxt_owner, nxt_conceded;
        logic exp_ren, exp_wen, exp_ihit, exp_dhit;
        logic [W-1:0] exp_addr, exp_store, exp_iload, exp_dload;
        logic d_want, i_first;
        owner = 0; conceded = 0;
        for (int n = 0; n < 500; n++) begin
            iREN   = ($urandom_range(0, 3) != 0);
            dREN   = ($urandom_range(0, 2) == 0);
            dWEN   = ($urandom_range(0, 3) == 0);
            iaddr  = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            #1;
            d_want = dREN | dWEN;
            exp_ren = 0; exp_wen = 0; exp_ihit = 0; exp_dhit = 0;
            exp_addr = '0; exp_store = '0; exp_iload = '0; exp_dload = '0;
            if (owner == 1 && d_want) begin
                exp_addr = daddr; exp_store = dstore;
                exp_wen = dWEN; exp_ren = dREN && !dWEN;
                exp_dhit = (ramstate == ACCESS);
                exp_dload = exp_dhit ? ramload : '0;
            end else if (owner == 2 && iREN) begin
                exp_addr = iaddr; exp_ren = 1;
                exp_ihit = (ramstate == ACCESS);
                exp_iload = exp_ihit ? ramload : '0;
            end
            checks++;
            if ({ramREN, ramWEN, ihit, dhit} !== {exp_ren, exp_wen, exp_ihit, exp_dhit}
                || iload !== exp_iload || dload !== exp_dload
                || ((exp_ren || exp_wen) && ramaddr !== exp_addr)
                || (exp_wen && ramstore !== exp_store)) begin
                failures++;
                $display("FAIL random_cycle%0d: ren/wen/ihit/dhit=%b addr=%h store=%h iload=%h dload=%h, required %b %h %h %h %h",
                         n, {ramREN, ramWEN, ihit, dhit}, ramaddr, ramstore, iload, dload,
                         {exp_ren, exp_wen, exp_ihit, exp_dhit}, exp_addr, exp_store, exp_iload, exp_dload);
            end
            nxt_owner = owner; nxt_conceded = conceded;
            if (owner == 0) begin
                i_first = 1'b0;
`ifdef MEM_ARB_STARVE_EN
                i_first = iREN && (conceded == 4);
`endif
                if (d_want && !i_first) begin
                    nxt_owner = 1;
                    if (iREN) nxt_conceded = conceded + 1;
                end else if (iREN) begin
                    nxt_owner = 2;
                    nxt_conceded = 0;
                end
                if (!iREN) nxt_conceded = 0;
            end else if (owner == 1) begin
                if (!d_want || ramstate == ACCESS || ramstate == ERROR) nxt_owner = 0;
            end else begin
                if (!iREN || ramstate == ACCESS || ramstate == ERROR) nxt_owner = 0;
            end
            tick();
            owner = nxt_owner; conceded = nxt_conceded;
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_priority();
        test_write_busy();
        test_error();
        test_reset_mid();
        test_starve();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
